// File: rtl/distance_pwm_pkg.sv
// rtl/distance_pwm_pkg.sv - shared types, defaults and clamp helper for the distance PWM path
package distance_pwm_pkg;

  localparam int DIST_WIDTH    = 13;
  localparam int PWM_MAX_COUNT = 3000;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT,
    HOLD,
    COUNT
  } state_t;

  // Distances at or beyond the PWM period all map to full duty.
  function automatic logic [31:0] clamp_dist(input logic [31:0] d, input logic [31:0] max_count);
    return (d >= max_count) ? max_count : d;
  endfunction

endpackage

// File: rtl/distance_pwm_scheduler_timer.sv
// rtl/distance_pwm_scheduler_timer.sv - PWM phase counter with wrap strobe and period_sync pulse
module pwm_period_timer
  import distance_pwm_pkg::*;
#(
  parameter int MAX_COUNT = PWM_MAX_COUNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic wrap,
  output logic period_sync
);

  localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  logic [PW-1:0] phase;

  assign wrap = enable && (phase == PW'(MAX_COUNT - 1));

  // period_sync marks the cycle where phase has just returned to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= '0;
      period_sync <= 1'b0;
    end else begin
      period_sync <= wrap;
      if (wrap) begin
        phase <= '0;
      end else if (enable) begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/distance_pwm_scheduler.sv
// rtl/distance_pwm_scheduler.sv - requests distance samples and commits them on PWM period boundaries
module distance_pwm_scheduler
  import distance_pwm_pkg::*;
#(
  parameter int WIDTH           = DIST_WIDTH,
  parameter int MAX_COUNT       = PWM_MAX_COUNT,
  parameter int SAMPLE_PERIODS  = 4,
  parameter int TIMEOUT_PERIODS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             sample_req,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             sample_ready,
  output logic [WIDTH-1:0] distance_out,
  output logic             period_sync,
  output logic             pwm_enable,
  output logic             stale
);

  localparam int CMAX = (SAMPLE_PERIODS > TIMEOUT_PERIODS) ? SAMPLE_PERIODS : TIMEOUT_PERIODS;
  localparam int CW   = $clog2(CMAX + 1);

  state_t           state;
  logic [CW-1:0]    pcount;
  logic [CW-1:0]    tcount;
  logic [WIDTH-1:0] shadow;
  logic             req_q;
  logic             ready_q;
  logic             wrap;
  logic             handshake;

  pwm_period_timer #(
    .MAX_COUNT(MAX_COUNT)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .wrap       (wrap),
    .period_sync(period_sync)
  );

  // Gating with enable drops the handshake lines in the very cycle enable falls.
  assign sample_req   = req_q && enable;
  assign sample_ready = ready_q && enable;
  assign handshake    = sample_valid && sample_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pcount       <= '0;
      tcount       <= '0;
      shadow       <= '0;
      req_q        <= 1'b0;
      ready_q      <= 1'b0;
      distance_out <= '0;
      stale        <= 1'b0;
      pwm_enable   <= 1'b0;
    end else begin
      pwm_enable <= enable;
      if (enable) begin
        req_q <= 1'b0;
        case (state)
          IDLE: begin
            state <= REQUEST;
            req_q <= 1'b1;
          end
          REQUEST: begin
            tcount  <= '0;
            ready_q <= 1'b1;
            state   <= WAIT;
          end
          WAIT: begin
            // A sample arriving on the final timeout wrap still counts.
            if (handshake) begin
              shadow  <= WIDTH'(clamp_dist(32'(sample_data), 32'(MAX_COUNT)));
              ready_q <= 1'b0;
              state   <= HOLD;
            end else if (wrap) begin
              if (tcount == CW'(TIMEOUT_PERIODS - 1)) begin
                stale   <= 1'b1;
                ready_q <= 1'b0;
                req_q   <= 1'b1;
                state   <= REQUEST;
              end else begin
                tcount <= tcount + 1'b1;
              end
            end
          end
          HOLD: begin
            if (wrap) begin
              distance_out <= shadow;
              stale        <= 1'b0;
              pcount       <= '0;
              state        <= COUNT;
            end
          end
          COUNT: begin
            if (wrap) begin
              if (pcount == CW'(SAMPLE_PERIODS - 1)) begin
                req_q <= 1'b1;
                state <= REQUEST;
              end else begin
                pcount <= pcount + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_distance_pwm_scheduler.sv
// tb/tb_distance_pwm_scheduler.sv - scoreboard bench for distance_pwm_scheduler
module tb_distance_pwm_scheduler;

  localparam int W  = 13;
  localparam int MC = 100;
  localparam int SP = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_data = '0;
  logic         sample_req;
  logic         sample_ready;
  logic [W-1:0] distance_out;
  logic         period_sync;
  logic         pwm_enable;
  logic         stale;

  distance_pwm_scheduler #(
    .WIDTH(W), .MAX_COUNT(MC), .SAMPLE_PERIODS(SP), .TIMEOUT_PERIODS(TO)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_req(sample_req), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .distance_out(distance_out), .period_sync(period_sync),
    .pwm_enable(pwm_enable), .stale(stale)
  );

  always #5 clk = ~clk;

  // Time base: number of rising edges seen with enable high since reset release.
  int now;
  bit last_en;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      now     <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= enable;
      if (enable) now <= now + 1;
    end
  end

  typedef struct {
    int t;
    int d;
    bit s;
  } commit_t;

  int      n_tests = 0;
  int      n_fail = 0;
  int      req_q[$];
  commit_t com_q[$];
  bit      mon_off = 1'b1;
  int      last_d = 0;
  bit      last_s = 1'b0;
  int      cur_tr;
  int      cur_d;
  bit      cur_s;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, now);
    end
  endtask

  function automatic int ceil_wrap(int x);
    return ((x + MC - 1) / MC) * MC;
  endfunction

  function automatic int next_wrap(int x);
    return (x / MC + 1) * MC;
  endfunction

  function automatic int clampf(int d);
    return (d >= MC) ? MC : d;
  endfunction

  function automatic int pick_data(int prev);
    int d;
    do begin
      if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 8191));
      else d = int'($urandom_range(0, MC + 10));
    end while (clampf(d) == prev);
    return d;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows a request or an output change.
  always @(negedge clk) begin
    if (mon_off) begin
      last_d = 0;
      last_s = 1'b0;
    end else begin
      if (period_sync || (last_en && now > 0 && now % MC == 0))
        check("period_sync", period_sync, last_en && now > 0 && now % MC == 0);
      if (req_q.size() > 0 && req_q[0] < now) begin
        check("sample_req_missed", now, req_q[0]);
        void'(req_q.pop_front());
      end
      if (sample_req) begin
        if (req_q.size() == 0) check("sample_req_unexpected", 1, 0);
        else check("sample_req_time", now, req_q.pop_front());
      end
      if (com_q.size() > 0 && com_q[0].t < now) begin
        check("commit_missed", now, com_q[0].t);
        void'(com_q.pop_front());
      end
      if (distance_out !== W'(last_d) || stale !== last_s) begin
        if (com_q.size() == 0) begin
          check("unexpected_distance", distance_out, last_d);
          check("unexpected_stale", stale, last_s);
        end else begin
          check("commit_time", now, com_q[0].t);
          check("distance_out", distance_out, com_q[0].d);
          check("stale", stale, com_q[0].s);
          void'(com_q.pop_front());
        end
        last_d = int'(distance_out);
        last_s = stale;
      end
    end
  end

  task automatic wait_until(int t);
    int guard = 0;
    while (now < t && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (now != t) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_until: at edge %0d target %0d", now, t);
    end
  endtask

  task automatic do_ok(int th, int data);
    int      tc;
    commit_t c;
    if (now <= cur_tr + 1) begin
      wait_until(cur_tr + 1);
      check("ready_after_req", sample_ready, 1);
    end
    wait_until(th - 1);
    check("ready_before_hs", sample_ready, 1);
    sample_valid = 1'b1;
    sample_data  = W'(data);
    tc   = next_wrap(th);
    c.t  = tc;
    c.d  = clampf(data);
    c.s  = 1'b0;
    com_q.push_back(c);
    cur_d  = c.d;
    cur_s  = 1'b0;
    cur_tr = tc + SP * MC;
    req_q.push_back(cur_tr);
    @(negedge clk);
    check("ready_after_hs", sample_ready, 0);
    sample_data = W'($urandom_range(0, 8191));
    @(negedge clk);
    sample_valid = 1'b0;
    wait_until(tc + 2);
    check("ready_in_count", sample_ready, 0);
    sample_valid = 1'b1;
    sample_data  = W'($urandom_range(0, 8191));
    @(negedge clk);
    sample_valid = 1'b0;
    wait_until(cur_tr);
  endtask

  task automatic do_timeout();
    int      tto;
    commit_t c;
    tto = ceil_wrap(cur_tr + 2) + (TO - 1) * MC;
    wait_until(cur_tr + 1);
    check("ready_after_req", sample_ready, 1);
    c.t = tto;
    c.d = cur_d;
    c.s = 1'b1;
    com_q.push_back(c);
    cur_s  = 1'b1;
    cur_tr = tto;
    req_q.push_back(cur_tr);
    wait_until(tto);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int th;
    repeat (3) @(negedge clk);
    check("rst_distance_out", distance_out, 0);
    check("rst_sample_req", sample_req, 0);
    check("rst_sample_ready", sample_ready, 0);
    check("rst_period_sync", period_sync, 0);
    check("rst_pwm_enable", pwm_enable, 0);
    check("rst_stale", stale, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    cur_tr  = 1;
    cur_d   = 0;
    cur_s   = 1'b0;
    req_q.push_back(1);
    mon_off = 1'b0;
    wait_until(1);
    check("pwm_enable_follows", pwm_enable, 1);

    do_ok(40, 60);
    do_ok(cur_tr + 2 + int'($urandom_range(0, 150)), 8000);
    do_ok(cur_tr + 2 + int'($urandom_range(0, 150)), 99);
    do_ok(cur_tr + 2 + int'($urandom_range(0, 150)), 0);
    do_timeout();
    do_ok(cur_tr + 7, 70);
    do_ok(ceil_wrap(cur_tr + 2) + (TO - 1) * MC, 33);
    do_ok(ceil_wrap(cur_tr + 2) + MC, 44);

    for (int i = 0; i < 14; i++) begin
      if (!cur_s && $urandom_range(0, 4) == 0) do_timeout();
      else do_ok(cur_tr + 2 + int'($urandom_range(0, 3 * MC)), pick_data(cur_d));
    end

    // Enable gap while waiting for a sample, then a reset in the middle of HOLD.
    wait_until(cur_tr + 1);
    check("ready_before_gap", sample_ready, 1);
    wait_until(cur_tr + 5);
    enable = 1'b0;
    #1;
    check("ready_gap_immediate", sample_ready, 0);
    check("pwm_enable_lag", pwm_enable, 1);
    @(negedge clk);
    check("pwm_enable_gap", pwm_enable, 0);
    repeat (998) @(negedge clk);
    check("ready_gap_end", sample_ready, 0);
    check("distance_gap_hold", distance_out, cur_d);
    enable = 1'b1;
    th = cur_tr + MC + 20;
    wait_until(th - 1);
    check("ready_after_gap", sample_ready, 1);
    sample_valid = 1'b1;
    sample_data  = W'(pick_data(cur_d));
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_hold", sample_ready, 0);
    wait_until(th + 5);
    #3;
    mon_off = 1'b1;
    reset_n = 1'b0;
    #1;
    check("arst_distance_out", distance_out, 0);
    check("arst_sample_req", sample_req, 0);
    check("arst_sample_ready", sample_ready, 0);
    check("arst_period_sync", period_sync, 0);
    check("arst_pwm_enable", pwm_enable, 0);
    check("arst_stale", stale, 0);
    req_q.delete();
    com_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cur_tr  = 1;
    cur_d   = 0;
    cur_s   = 1'b0;
    req_q.push_back(1);
    mon_off = 1'b0;
    do_ok(cur_tr + 2 + int'($urandom_range(0, 50)), pick_data(0));
    wait_until(cur_tr + 1);
    check("req_queue_empty", req_q.size(), 0);
    check("commit_queue_empty", com_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
